// File: rtl/fifo8_sched_pkg.sv
// Shared constants and read-FSM encoding for the byte FIFO scheduler.
package fifo8_sched_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned LVL_W  = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } rd_state_e;

endpackage

// File: rtl/fifo8_sched_if.sv
// Bundle of producer, FIFO and consumer signals around the scheduler.
interface fifo8_sched_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) ();
  import fifo8_sched_pkg::*;

  logic [NREQ-1:0]        req_valid;
  logic [BYTE_W*NREQ-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic [IDW-1:0]         grant_id;
  logic [BYTE_W-1:0]      fifo_wdata;
  logic                   fifo_write;
  logic                   fifo_full;
  logic                   fifo_read;
  logic [BYTE_W-1:0]      fifo_rdata;
  logic                   fifo_empty;
  logic                   out_valid;
  logic [BYTE_W-1:0]      out_data;
  logic                   out_ready;
  logic [LVL_W-1:0]       level;

  // The scheduler block itself
  modport master (
    input  req_valid, req_data, fifo_full, fifo_rdata, fifo_empty, out_ready,
    output req_ready, grant_id, fifo_wdata, fifo_write, fifo_read, out_valid, out_data, level
  );

  // Producers, FIFO and consumer around it
  modport slave (
    output req_valid, req_data, fifo_full, fifo_rdata, fifo_empty, out_ready,
    input  req_ready, grant_id, fifo_wdata, fifo_write, fifo_read, out_valid, out_data, level
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first request above ptr, wrapping at NREQ.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            any
);

  logic [IDW-1:0] idx;

  // Scan ptr+1 .. ptr+NREQ; the last slot scanned is ptr itself
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    idx    = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = IDW'((32'(ptr) + k) % NREQ);
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

endmodule

// File: rtl/fifo8_sched.sv
// Write-side arbiter and read-side sequencer for the shared 256-entry byte FIFO.
module fifo8_sched
  import fifo8_sched_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input logic          CLK,
  input logic          RST_N,
  fifo8_sched_if.master bus
);

  logic [IDW-1:0]    ptr_q;
  logic [IDW-1:0]    grant_id_q;
  logic [NREQ-1:0]   gnt;
  logic [IDW-1:0]    gnt_id;
  logic              any;
  logic              grant;
  logic              rd;
  logic [BYTE_W-1:0] wdata;
  rd_state_e         state_q;
  logic              out_valid_q;
  logic [BYTE_W-1:0] out_data_q;
  logic [LVL_W-1:0]  level_q;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_pick (
    .req    (bus.req_valid),
    .ptr    (ptr_q),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .any    (any)
  );

  // Strobes are gated by RST_N so they drop the instant reset asserts
  assign grant = RST_N & any & ~bus.fifo_full;
  assign rd    = RST_N & ~bus.fifo_empty &
                 ((state_q == ST_IDLE) | ((state_q == ST_HOLD) & bus.out_ready));

  // Route the winning producer's byte to the FIFO write port
  always_comb begin
    wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) wdata = bus.req_data[i*BYTE_W +: BYTE_W];
    end
  end

  assign bus.req_ready  = grant ? gnt : '0;
  assign bus.fifo_write = grant;
  assign bus.fifo_wdata = wdata;
  assign bus.fifo_read  = rd;
  assign bus.grant_id   = grant_id_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.level      = level_q;

  // Round-robin pointer; reset to NREQ-1 so producer 0 is searched first
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ptr_q      <= IDW'(NREQ - 1);
      grant_id_q <= '0;
    end else if (grant) begin
      ptr_q      <= gnt_id;
      grant_id_q <= gnt_id;
    end
  end

  // Read FSM: pop, absorb the FIFO's one-cycle read latency, hold until accepted
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rd) state_q <= ST_FETCH;
        end
        ST_FETCH: begin
          out_data_q  <= bus.fifo_rdata;
          out_valid_q <= 1'b1;
          state_q     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= rd ? ST_FETCH : ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Occupancy as seen by this block; deliberately wraps rather than saturates
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      level_q <= '0;
    end else begin
      unique case ({grant, rd})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo8_sched.sv
// Scoreboard bench for fifo8_sched with a behavioural 256-entry FIFO model.
module tb_fifo8_sched;
  import fifo8_sched_pkg::*;

  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;

  typedef struct {
    int         id;
    logic [7:0] d;
  } wr_t;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic force_full = 1'b0;
  int   fcnt;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   last_wr_cyc = 0;
  int   rise_cyc = 0;
  int   rise_cnt = 0;
  logic [NREQ-1:0] taken;

  wr_t        exp_w[$];
  logic [7:0] exp_q[$];
  logic [7:0] pq[NREQ][$];
  logic [7:0] fq[$];
  int         hs_cyc[$];

  fifo8_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  fifo8_sched #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  assign bus.fifo_empty = (fcnt == 0);
  assign bus.fifo_full  = force_full || (fcnt >= 256);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Issue one producer byte and record the write and output it must cause
  task automatic send(input int p, input logic [7:0] d);
    pq[p].push_back(d);
    exp_w.push_back('{id: p, d: d});
    exp_q.push_back(d);
  endtask

  task automatic set_ready(input logic v);
    @(posedge CLK);
    #2 bus.out_ready = v;
  endtask

  task automatic set_full(input logic v);
    @(posedge CLK);
    #2 force_full = v;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || exp_w.size() != 0 || bus.out_valid || bus.level != 0)
           && n < 500) begin
      @(negedge CLK);
      n++;
    end
    check("drain_pending", exp_q.size() + exp_w.size(), 0);
    check("drain_timeout", n >= 500, 0);
  endtask

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // FIFO model with registered read data; its contents survive RST_N
  initial begin
    fcnt <= 0;
    bus.fifo_rdata <= '0;
    forever begin
      @(posedge CLK);
      if (bus.fifo_write) fq.push_back(bus.fifo_wdata);
      if (bus.fifo_read && fq.size() != 0) bus.fifo_rdata <= fq.pop_front();
      fcnt <= fq.size();
    end
  end

  // Producer driver: retire accepted bytes, present each queue head
  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    forever begin
      @(posedge CLK);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (taken[i] && pq[i].size() != 0) void'(pq[i].pop_front());
        bus.req_valid[i] = (pq[i].size() != 0);
        bus.req_data[i*8 +: 8] = (pq[i].size() != 0) ? pq[i][0] : 8'h00;
      end
    end
  end

  // Monitor: pops both scoreboards and checks protocol rules every cycle
  initial begin
    logic       pv, pr;
    logic [7:0] pd;
    bit         gchk;
    int         gexp;
    wr_t        e;
    pv = 1'b0; pr = 1'b0; pd = '0; gchk = 1'b0; gexp = 0;
    forever begin
      @(negedge CLK);
      taken = RST_N ? bus.req_ready : '0;
      if (!RST_N) begin
        gchk = 1'b0;
        pv   = 1'b0;
      end else begin
        if (gchk) check("grant_id", bus.grant_id, gexp);
        gchk = 1'b0;
        check("ready_iff_write", |bus.req_ready, bus.fifo_write);
        if (bus.fifo_full) check("write_while_full", bus.fifo_write, 0);
        if (bus.fifo_write) begin
          last_wr_cyc = cyc;
          if (exp_w.size() == 0) begin
            check("unexpected_write", bus.fifo_write, 0);
          end else begin
            e = exp_w.pop_front();
            check("req_ready", bus.req_ready, 32'(1 << e.id));
            check("fifo_wdata", bus.fifo_wdata, e.d);
            gchk = 1'b1;
            gexp = e.id;
          end
        end
        if (bus.fifo_read) check("read_while_empty", bus.fifo_empty, 0);
        check("level", bus.level, fcnt);
        if (bus.out_valid && !pv) begin
          rise_cyc = cyc;
          rise_cnt++;
        end
        if (bus.out_valid && pv && !pr) check("hold_stable", bus.out_data, pd);
        if (bus.out_valid && bus.out_ready) begin
          hs_cyc.push_back(cyc);
          if (exp_q.size() == 0) check("unexpected_output", bus.out_valid, 0);
          else check("out_data", bus.out_data, exp_q.pop_front());
        end
        pv = bus.out_valid;
        pr = bus.out_ready;
        pd = bus.out_data;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int r0;
    bus.out_ready = 1'b1;

    // Reset values
    #12;
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_fifo_write", bus.fifo_write, 0);
    check("rst_fifo_read", bus.fifo_read, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_grant_id", bus.grant_id, 0);
    check("rst_level", bus.level, 0);
    @(negedge CLK);
    RST_N = 1'b1;

    // Single byte, empty to first output
    @(negedge CLK);
    r0 = rise_cnt;
    send(0, 8'hA5);
    n = 0;
    while (rise_cnt == r0 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    check("first_out_seen", rise_cnt != r0, 1);
    check("first_out_latency", rise_cyc - last_wr_cyc, 3);
    wait_drain();

    // Park the pointer on 3, then four producers contend with two bytes each
    @(negedge CLK);
    send(3, 8'h33);
    wait_drain();
    @(negedge CLK);
    for (int r = 0; r < 2; r++) begin
      for (int p = 0; p < 4; p++) send(p, 8'(16 * (p + 1)));
    end
    wait_drain();

    // FIFO full with producers 2 and 0 waiting; pointer parked on 1
    @(negedge CLK);
    send(1, 8'h11);
    wait_drain();
    set_full(1'b1);
    @(negedge CLK);
    send(2, 8'h22);
    send(0, 8'h02);
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      check("full_req_ready", bus.req_ready, 0);
      check("full_fifo_write", bus.fifo_write, 0);
    end
    set_full(1'b0);
    wait_drain();

    // Consumer stalls with 5 bytes queued, then drains
    set_ready(1'b0);
    @(negedge CLK);
    for (int k = 0; k < 5; k++) send(1, 8'(8'h51 + k));
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(negedge CLK);
      n++;
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      check("stall_out_valid", bus.out_valid, 1);
      check("stall_out_data", bus.out_data, 8'h51);
      check("stall_fifo_read", bus.fifo_read, 0);
    end
    check("stall_level", bus.level, 4);
    hs_cyc.delete();
    set_ready(1'b1);
    wait_drain();
    check("drain_count", hs_cyc.size(), 5);
    for (int i = 1; i < hs_cyc.size(); i++) check("drain_gap", hs_cyc[i] - hs_cyc[i-1], 2);

    // Simultaneous write and read at level 7
    set_ready(1'b0);
    @(negedge CLK);
    for (int k = 0; k < 8; k++) send(2, 8'(8'h60 + k));
    n = 0;
    while (bus.level != 7 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    check("level7_reached", bus.level, 7);
    send(2, 8'h68);
    set_ready(1'b1);
    @(negedge CLK);
    check("both_write", bus.fifo_write, 1);
    check("both_read", bus.fifo_read, 1);
    check("both_level_before", bus.level, 7);
    @(negedge CLK);
    check("both_level_after", bus.level, 7);
    wait_drain();

    // Reset while in FETCH: that byte is lost
    @(negedge CLK);
    send(1, 8'h77);
    n = 0;
    while (!bus.fifo_read && n < 50) begin
      @(negedge CLK);
      n++;
    end
    check("pre_reset_read", bus.fifo_read, 1);
    @(posedge CLK);
    #2 RST_N = 1'b0;
    #1;
    check("arst_req_ready", bus.req_ready, 0);
    check("arst_fifo_write", bus.fifo_write, 0);
    check("arst_fifo_read", bus.fifo_read, 0);
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_out_data", bus.out_data, 0);
    check("arst_grant_id", bus.grant_id, 0);
    check("arst_level", bus.level, 0);
    void'(exp_q.pop_back());
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    check("post_reset_out_valid", bus.out_valid, 0);
    send(0, 8'hB0);
    send(3, 8'hB3);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
